// File: rtl/control_step_sequencer.sv
// Control-step sequencer: walks an instruction through steps 1..limit with stall,
// early-end, halt-at-boundary and back-to-back start support. All outputs registered.
module control_step_sequencer #(
    parameter int MAX_STEPS = 20
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [4:0]           step_limit,
    input  logic                 stall,
    input  logic                 end_early,
    input  logic                 halt_req,
    input  logic                 resume,
    output logic [4:0]           step,
    output logic [MAX_STEPS-1:0] step_onehot,
    output logic                 busy,
    output logic                 instr_done,
    output logic                 halted
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    localparam logic [4:0] MAX_L = 5'(MAX_STEPS);

    state_t               state_q, state_d;
    logic [4:0]           step_q, step_d;
    logic [4:0]           limit_q, limit_d;
    logic                 done_d;
    logic [MAX_STEPS-1:0] onehot_q;
    logic                 busy_q, done_q, halted_q;

    // A zero limit still runs one step; oversize limits saturate at MAX_STEPS.
    function automatic logic [4:0] eff_limit(input logic [4:0] lim);
        logic [4:0] r;
        if (lim == 5'd0) begin
            r = 5'd1;
        end else if (lim > MAX_L) begin
            r = MAX_L;
        end else begin
            r = lim;
        end
        return r;
    endfunction

    function automatic logic [MAX_STEPS-1:0] decode(input logic [4:0] s);
        logic [MAX_STEPS-1:0] oh;
        oh = '0;
        for (int i = 0; i < MAX_STEPS; i++) begin
            oh[i] = (s == 5'(i + 1));
        end
        return oh;
    endfunction

    // Next-state logic for state, step, latched limit and completion pulse.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        limit_d = limit_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (halt_req) begin
                    state_d = S_HALTED;
                    step_d  = 5'd0;
                end else if (start) begin
                    state_d = S_RUN;
                    step_d  = 5'd1;
                    limit_d = eff_limit(step_limit);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (stall) begin
                    state_d = S_RUN;
                end else if ((step_q >= limit_q) || end_early) begin
                    done_d = 1'b1;
                    // halt_req only matters at the boundary, and it beats a pending start.
                    if (halt_req) begin
                        state_d = S_HALTED;
                        step_d  = 5'd0;
                    end else if (start) begin
                        state_d = S_RUN;
                        step_d  = 5'd1;
                        limit_d = eff_limit(step_limit);
                    end else begin
                        state_d = S_IDLE;
                        step_d  = 5'd0;
                    end
                end else begin
                    step_d = step_q + 5'd1;
                end
            end
            S_HALTED: begin
                if (resume) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_HALTED;
                end
                step_d = 5'd0;
            end
            default: begin
                state_d = S_IDLE;
                step_d  = 5'd0;
                limit_d = 5'd1;
            end
        endcase
    end

    // State and registered output update with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            step_q   <= 5'd0;
            limit_q  <= 5'd1;
            onehot_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            limit_q  <= limit_d;
            onehot_q <= decode(step_d);
            busy_q   <= (state_d == S_RUN);
            done_q   <= done_d;
            halted_q <= (state_d == S_HALTED);
        end
    end

    assign step        = step_q;
    assign step_onehot = onehot_q;
    assign busy        = busy_q;
    assign instr_done  = done_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_control_step_sequencer.sv
// Directed self-checking bench for control_step_sequencer using immediate assertions.
module tb_control_step_sequencer;

    localparam int MAX_STEPS = 20;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 start = 1'b0;
    logic [4:0]           step_limit = 5'd0;
    logic                 stall = 1'b0;
    logic                 end_early = 1'b0;
    logic                 halt_req = 1'b0;
    logic                 resume = 1'b0;
    logic [4:0]           step;
    logic [MAX_STEPS-1:0] step_onehot;
    logic                 busy;
    logic                 instr_done;
    logic                 halted;

    int n_checks = 0;
    int n_fail   = 0;

    control_step_sequencer #(.MAX_STEPS(MAX_STEPS)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .step_limit  (step_limit),
        .stall       (stall),
        .end_early   (end_early),
        .halt_req    (halt_req),
        .resume      (resume),
        .step        (step),
        .step_onehot (step_onehot),
        .busy        (busy),
        .instr_done  (instr_done),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int s, input logic b, input logic d, input logic h);
        logic [MAX_STEPS-1:0] oh;
        oh = '0;
        if (s > 0) oh[s-1] = 1'b1;
        chk({tag, ".step"},   32'(step),        32'(s));
        chk({tag, ".onehot"}, 32'(step_onehot), 32'(oh));
        chk({tag, ".busy"},   32'(busy),        32'(b));
        chk({tag, ".done"},   32'(instr_done),  32'(d));
        chk({tag, ".halted"}, 32'(halted),      32'(h));
    endtask

    initial begin
        // Reset
        tick();
        chk_all("reset", 0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        tick();
        chk_all("idle", 0, 1'b0, 1'b0, 1'b0);

        // 3-step instruction with explicit one-hot values
        start = 1'b1; step_limit = 5'd3;
        tick(); start = 1'b0;
        chk_all("l3.s1", 1, 1'b1, 1'b0, 1'b0);
        chk("l3.oh1", 32'(step_onehot), 32'h00001);
        tick(); chk("l3.oh2", 32'(step_onehot), 32'h00002);
        chk_all("l3.s2", 2, 1'b1, 1'b0, 1'b0);
        tick(); chk("l3.oh3", 32'(step_onehot), 32'h00004);
        chk_all("l3.s3", 3, 1'b1, 1'b0, 1'b0);
        tick(); chk_all("l3.done", 0, 1'b0, 1'b1, 1'b0);
        tick(); chk_all("l3.after", 0, 1'b0, 1'b0, 1'b0);

        // 5 steps, stall at step 2 for two cycles
        start = 1'b1; step_limit = 5'd5;
        tick(); start = 1'b0; chk_all("st.s1", 1, 1'b1, 1'b0, 1'b0);
        tick(); chk_all("st.s2", 2, 1'b1, 1'b0, 1'b0);
        stall = 1'b1;
        tick(); chk_all("st.h1", 2, 1'b1, 1'b0, 1'b0);
        tick(); chk_all("st.h2", 2, 1'b1, 1'b0, 1'b0);
        stall = 1'b0;
        tick(); chk_all("st.s3", 3, 1'b1, 1'b0, 1'b0);
        tick(); chk_all("st.s4", 4, 1'b1, 1'b0, 1'b0);
        tick(); chk_all("st.s5", 5, 1'b1, 1'b0, 1'b0);
        stall = 1'b1; end_early = 1'b1;
        tick(); chk_all("st.prio", 5, 1'b1, 1'b0, 1'b0);
        stall = 1'b0; end_early = 1'b0;
        tick(); chk_all("st.done", 0, 1'b0, 1'b1, 1'b0);
        tick(); chk_all("st.after", 0, 1'b0, 1'b0, 1'b0);

        // 8 steps ended early at step 4
        start = 1'b1; step_limit = 5'd8;
        tick(); start = 1'b0; chk_all("ee.s1", 1, 1'b1, 1'b0, 1'b0);
        tick(); tick(); tick(); chk_all("ee.s4", 4, 1'b1, 1'b0, 1'b0);
        end_early = 1'b1;
        tick(); end_early = 1'b0; chk_all("ee.done", 0, 1'b0, 1'b1, 1'b0);
        tick(); chk_all("ee.after", 0, 1'b0, 1'b0, 1'b0);

        // halt_req pulsed mid-instruction has no effect
        start = 1'b1; step_limit = 5'd3;
        tick(); start = 1'b0; halt_req = 1'b1;
        tick(); halt_req = 1'b0; chk_all("hp.s2", 2, 1'b1, 1'b0, 1'b0);
        tick(); tick(); chk_all("hp.done", 0, 1'b0, 1'b1, 1'b0);

        // halt_req held through completion with start pending
        start = 1'b1; step_limit = 5'd3;
        tick(); start = 1'b0;
        tick(); halt_req = 1'b1; chk_all("hl.s2", 2, 1'b1, 1'b0, 1'b0);
        tick(); start = 1'b1; chk_all("hl.s3", 3, 1'b1, 1'b0, 1'b0);
        tick(); chk_all("hl.done", 0, 1'b0, 1'b1, 1'b1);
        halt_req = 1'b0;
        tick(); chk_all("hl.ign_start", 0, 1'b0, 1'b0, 1'b1);
        resume = 1'b1;
        tick(); resume = 1'b0; start = 1'b0;
        chk_all("hl.resume", 0, 1'b0, 1'b0, 1'b0);
        tick(); chk_all("hl.idle", 0, 1'b0, 1'b0, 1'b0);

        // In IDLE, halt_req beats start; resume outside HALTED is ignored
        halt_req = 1'b1; start = 1'b1;
        tick(); halt_req = 1'b0; start = 1'b0; chk_all("ih.halt", 0, 1'b0, 1'b0, 1'b1);
        resume = 1'b1;
        tick(); chk_all("ih.resume", 0, 1'b0, 1'b0, 1'b0);
        tick(); resume = 1'b0; chk_all("ih.res_idle", 0, 1'b0, 1'b0, 1'b0);

        // Back-to-back: limits 2, 0 (->1), 25 (->20)
        start = 1'b1; step_limit = 5'd2;
        tick(); chk_all("bb.a1", 1, 1'b1, 1'b0, 1'b0);
        tick(); chk_all("bb.a2", 2, 1'b1, 1'b0, 1'b0);
        step_limit = 5'd0;
        tick(); chk_all("bb.b1", 1, 1'b1, 1'b1, 1'b0);
        step_limit = 5'd25;
        tick(); start = 1'b0; chk_all("bb.c1", 1, 1'b1, 1'b1, 1'b0);
        for (int i = 2; i <= 20; i++) begin
            tick(); chk_all("bb.c", i, 1'b1, 1'b0, 1'b0);
        end
        tick(); chk_all("bb.done", 0, 1'b0, 1'b1, 1'b0);
        tick(); chk_all("bb.after", 0, 1'b0, 1'b0, 1'b0);

        // Reset mid-instruction at step 6
        start = 1'b1; step_limit = 5'd10;
        tick(); start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk_all("rs.s6", 6, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        tick(); chk_all("rs.reset", 0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        tick(); chk_all("rs.after", 0, 1'b0, 1'b0, 1'b0);

        // Latched limit returns to the sampled value on the next start
        start = 1'b1; step_limit = 5'd1;
        tick(); start = 1'b0; chk_all("l1.s1", 1, 1'b1, 1'b0, 1'b0);
        tick(); chk_all("l1.done", 0, 1'b0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/control_step_sequencer.md
CONTROL_STEP_SEQUENCER -- requirements
Module: control_step_sequencer

Interface
REQ-001 SHALL have parameter MAX_STEPS, default 20, meaning the highest control step and the one-hot output width.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: request to begin an instruction's step sequence.
REQ-005 SHALL have port step_limit, input, 5 bits: number of steps in the instruction, sampled when a start is accepted.
REQ-006 SHALL have port stall, input, 1 bit: hold the current step.
REQ-007 SHALL have port end_early, input, 1 bit: the current step is the instruction's last step.
REQ-008 SHALL have port halt_req, input, 1 bit: enter HALTED at the next instruction boundary.
REQ-009 SHALL have port resume, input, 1 bit: leave HALTED.
REQ-010 SHALL have port step, output, 5 bits: current binary step; 0 means no step active.
REQ-011 SHALL have port step_onehot, output, MAX_STEPS bits: one-hot decode of step.
REQ-012 SHALL have port busy, output, 1 bit: high while state is RUN.
REQ-013 SHALL have port instr_done, output, 1 bit: one-cycle pulse on instruction completion.
REQ-014 SHALL have port halted, output, 1 bit: high while state is HALTED.

Function
REQ-015 SHALL implement exactly three states: IDLE, RUN and HALTED; all outputs SHALL be registered.
REQ-016 SHALL drive step_onehot to all zeros when step=0; otherwise bit (step-1) SHALL be the only bit high, so step 1 maps to bit 0.
REQ-017 SHALL latch the effective limit at start acceptance: step_limit=0 becomes 1, and step_limit>MAX_STEPS is clamped to MAX_STEPS.
REQ-018 In IDLE, halt_req=1 SHALL take priority over start: next state HALTED, step stays 0.
REQ-019 In IDLE, start=1 with halt_req=0 SHALL give next state RUN and step=1 on the next edge; latency from start to step 1 is one cycle.
REQ-020 In RUN with stall=1, step, state and latched limit SHALL hold; stall SHALL take priority over end_early and over limit completion.
REQ-021 In RUN with stall=0, when step is below the limit and end_early=0, step SHALL increment by 1.
REQ-022 In RUN with stall=0, when step equals the limit or end_early=1, the instruction SHALL complete: instr_done=1 on the next cycle only.
REQ-023 On completion with halt_req=1 (sampled in the completion cycle), SHALL go to HALTED with step=0, regardless of start.
REQ-024 On completion with halt_req=0 and start=1, SHALL stay in RUN with step=1 and a newly latched limit: back-to-back instructions with no idle cycle.
REQ-025 On completion with halt_req=0 and start=0, SHALL go to IDLE with step=0.
REQ-026 halt_req asserted mid-instruction and deasserted before the completion cycle SHALL have no effect.
REQ-027 start while in RUN (outside the completion cycle) or while in HALTED SHALL be ignored.
REQ-028 In HALTED, resume=1 SHALL give next state IDLE; resume SHALL be ignored in other states; a start in the same cycle as resume SHALL be ignored.
REQ-029 step SHALL never exceed the latched limit or MAX_STEPS; no wrap-around from MAX_STEPS to 1 without a completion.

Reset
REQ-030 reset=1 on a rising edge SHALL force: state IDLE, step=0, step_onehot=0, busy=0, instr_done=0, halted=0, latched limit=1.
REQ-031 reset SHALL take priority over all inputs in any state, including mid-instruction, and SHALL not produce an instr_done pulse.

Verification
REQ-032 start with step_limit=3 from IDLE -> step 1,2,3 on consecutive cycles, step_onehot 0x00001, 0x00002, 0x00004, then instr_done=1 with step=0 and busy=0.
REQ-033 step_limit=5 with stall=1 during step 2 for 2 cycles -> step sequence 1,2,2,2,3,4,5; single instr_done pulse.
REQ-034 step_limit=8 with end_early=1 at step 4 -> instr_done after step 4; step never reaches 5.
REQ-035 halt_req=1 during step 2 of a 3-step instruction, held through completion, with start=1 -> completes, then halted=1, step=0; resume -> IDLE; a start in the resume cycle is ignored.
REQ-036 start held high with step_limit=2, then 0, then 25 -> steps 1,2 | 1 | 1..20 with no idle gaps; instr_done pulses after 2, 1 and 20 steps.
REQ-037 reset asserted at step 6 -> next cycle all outputs at reset values and no instr_done pulse.
